// File: rtl/fp_bus_pkg.sv
// Shared types and constants for the FP wrapper bus host.
package fp_bus_pkg;

  localparam int unsigned BUS_W = 32;
  localparam logic [BUS_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    START,
    WAIT,
    READ,
    RESP
  } fp_host_state_t;

endpackage

// File: rtl/fp_bus_host.sv
// Host-side master: serialises an operand pair onto the FP wrapper bus, runs the core,
// and returns the result (or a qNaN on watchdog expiry) over a valid/ready response port.
module fp_bus_host
  import fp_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [BUS_W-1:0] op_a,
  input  logic [BUS_W-1:0] op_b,
  output logic [BUS_W-1:0] bus_out,
  output logic             ld_a,
  output logic             ld_b,
  output logic             fp_start,
  input  logic             fp_done,
  output logic             rd_en,
  input  logic [BUS_W-1:0] bus_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [BUS_W-1:0] res_data,
  output logic             res_err,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int unsigned WD_W = 16;

  fp_host_state_t   state_q, state_d;
  logic [BUS_W-1:0] a_hold_q, a_hold_d;
  logic [BUS_W-1:0] b_hold_q, b_hold_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [BUS_W-1:0] res_data_q, res_data_d;
  logic             res_err_q, res_err_d;
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;

  // State and datapath registers; reset wins over any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
      wd_q       <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      txn_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      a_hold_q   <= a_hold_d;
      b_hold_q   <= b_hold_d;
      wd_q       <= wd_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      txn_cnt_q  <= txn_cnt_d;
    end
  end

  // Next-state, watchdog and result capture.
  always_comb begin
    state_d    = state_q;
    a_hold_d   = a_hold_q;
    b_hold_d   = b_hold_q;
    wd_d       = wd_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    txn_cnt_d  = txn_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          a_hold_d = op_a;
          b_hold_d = op_b;
          state_d  = SEND_A;
        end
      end
      SEND_A: state_d = SEND_B;
      SEND_B: state_d = START;
      START: begin
        wd_d    = '0;
        state_d = fp_done ? READ : WAIT;
      end
      WAIT: begin
        wd_d = wd_q + WD_W'(1);
        // A done arriving on the last watchdog cycle still takes the normal read path.
        if (fp_done) begin
          state_d = READ;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          res_data_d = FP_QNAN;
          res_err_d  = 1'b1;
          state_d    = RESP;
        end
      end
      READ: begin
        res_data_d = bus_in;
        res_err_d  = 1'b0;
        state_d    = RESP;
      end
      RESP: begin
        if (res_ready) begin
          txn_cnt_d = txn_cnt_q + CNT_W'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decoded from the registered state.
  always_comb begin
    op_ready  = 1'b0;
    bus_out   = '0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    fp_start  = 1'b0;
    rd_en     = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      IDLE:   op_ready = 1'b1;
      SEND_A: begin
        bus_out = a_hold_q;
        ld_a    = 1'b1;
      end
      SEND_B: begin
        bus_out = b_hold_q;
        ld_b    = 1'b1;
      end
      START:  fp_start  = 1'b1;
      READ:   rd_en     = 1'b1;
      RESP:   res_valid = 1'b1;
      default: ;
    endcase
  end

  assign res_data = res_data_q;
  assign res_err  = res_err_q;
  assign txn_cnt  = txn_cnt_q;

endmodule

// File: tb/tb_fp_bus_host.sv
// Randomised self-checking bench for fp_bus_host with a cycle-timeline reference model.
module tb_fp_bus_host;
  import fp_bus_pkg::*;

  localparam int unsigned TMO = 8;
  localparam int unsigned CW  = 2;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid, op_ready;
  logic [31:0]   op_a, op_b, bus_out, bus_in, res_data;
  logic          ld_a, ld_b, fp_start, fp_done, rd_en;
  logic          res_valid, res_ready, res_err;
  logic [CW-1:0] txn_cnt;

  logic [31:0] fp_res;
  logic [31:0] junk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_cnt = 0;

  fp_bus_host #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .bus_out(bus_out), .ld_a(ld_a), .ld_b(ld_b), .fp_start(fp_start),
    .fp_done(fp_done), .rd_en(rd_en), .bus_in(bus_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  // Wrapper output bus only carries the result while the tristate is enabled.
  assign bus_in = rd_en ? fp_res : junk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] ctl_obs();
    return 32'({op_ready, ld_a, ld_b, fp_start, rd_en, res_valid});
  endfunction

  // One transaction; cycle 0 is the accept cycle. d = cycles from start to done
  // (d > TMO means the core never answers in time), hold = RESP cycles with res_ready low.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                         input int d, input int hold, input bit keep_valid);
    bit ok;
    int rd_c, resp_c, hs_c;
    logic [5:0] ev;
    ok     = (d <= int'(TMO));
    rd_c   = ok ? 4 + d : -1;
    resp_c = ok ? 5 + d : 4 + int'(TMO);
    hs_c   = resp_c + hold;
    fp_res = r;
    for (int n = 0; n <= hs_c; n++) begin
      @(negedge clk);
      junk = $urandom;
      ev = {n == 0, n == 1, n == 2, n == 3, n == rd_c, n >= resp_c};
      chk("ctl", ctl_obs(), 32'(ev));
      chk("bus_out", bus_out, (n == 1) ? a : (n == 2) ? b : 32'h0);
      if (n == 0) chk("txn_cnt", 32'(txn_cnt), 32'(exp_cnt));
      if (n >= resp_c) begin
        chk("res_data", res_data, ok ? r : 32'h7FC0_0000);
        chk("res_err", 32'(res_err), ok ? 32'h0 : 32'h1);
      end
      op_valid  = (n == 0) || keep_valid;
      op_a      = (n == 0) ? a : $urandom;
      op_b      = (n == 0) ? b : $urandom;
      fp_done   = (n == 3 + d) || ((n < 3 || n > 3 + d) && ($urandom_range(0, 1) == 1));
      res_ready = (n < resp_c) ? 1'($urandom_range(0, 1)) : (n == hs_c);
    end
    op_valid = 1'b0;
    exp_cnt  = (exp_cnt + 1) % (1 << CW);
  endtask

  task automatic reset_mid();
    for (int n = 0; n <= 8; n++) begin
      @(negedge clk);
      junk      = $urandom;
      op_valid  = (n == 0);
      op_a      = $urandom;
      op_b      = $urandom;
      fp_done   = 1'b0;
      res_ready = 1'b0;
      if (n == 8) begin
        chk("wait_ctl", ctl_obs(), 32'h0);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    rst      = 1'b0;
    op_valid = 1'b0;
    fp_done  = 1'b1;
    chk("rst_ctl", ctl_obs(), 32'h20);
    chk("rst_bus", bus_out, 32'h0);
    chk("rst_data", res_data, 32'h0);
    chk("rst_err", 32'(res_err), 32'h0);
    chk("rst_cnt", 32'(txn_cnt), 32'h0);
    @(negedge clk);
    fp_done = 1'b0;
    chk("late_done", ctl_obs(), 32'h20);
    exp_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got running, want finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0;
    fp_done = 1'b0; res_ready = 1'b0; fp_res = '0; junk = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ctl", ctl_obs(), 32'h20);
    chk("reset_bus", bus_out, 32'h0);
    chk("reset_data", res_data, 32'h0);
    chk("reset_err", 32'(res_err), 32'h0);
    chk("reset_cnt", 32'(txn_cnt), 32'h0);

    run_txn(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3, 0, 1'b0);
    run_txn($urandom, $urandom, $urandom, 0, 0, 1'b0);
    run_txn($urandom, $urandom, $urandom, NEVER, 1, 1'b0);
    run_txn($urandom, $urandom, $urandom, int'(TMO), 0, 1'b0);
    run_txn($urandom, $urandom, $urandom, int'(TMO) + 1, 0, 1'b0);
    run_txn($urandom, $urandom, $urandom, 2, 10, 1'b1);
    for (int i = 0; i < 20; i++)
      run_txn($urandom, $urandom, $urandom, int'($urandom_range(0, 10)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    reset_mid();
    for (int i = 0; i < 5; i++)
      run_txn($urandom, $urandom, $urandom, int'($urandom_range(0, 4)), 0, 1'b0);
    @(negedge clk);
    chk("cnt_wrap", 32'(txn_cnt), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fp_bus_host.md
Name: fp_bus_host

Overview:
- Host-side master for the FP wrapper's shared 32-bit bus.
- Accepts an operand pair on a valid/ready interface and serialises it onto the wrapper input bus: A first, with the A-load strobe; then B, with the B-load strobe.
- Pulses start to the FP core, waits for done, then enables the wrapper's tristate output and captures the result.
- Returns the result on a valid/ready response interface, with a watchdog timeout.

Parameters:
- TIMEOUT, 64: maximum cycles spent in WAIT before the transaction aborts (range 2..65535).
- CNT_W, 16: width of the completed-transaction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  operand pair valid
- op_ready  out  1  block can accept an operand pair
- op_a  in  32  operand A (IEEE-754 single)
- op_b  in  32  operand B
- bus_out  out  32  drives the wrapper input bus
- ld_a  out  1  load strobe for wrapper register A
- ld_b  out  1  load strobe for wrapper register B
- fp_start  out  1  one-cycle start pulse to the FP core
- fp_done  in  1  FP core result-ready indication
- rd_en  out  1  tristate enable for the wrapper output bus
- bus_in  in  32  wrapper output bus
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts the result
- res_data  out  32  captured result
- res_err  out  1  result is a timeout substitute
- txn_cnt  out  CNT_W  completed transactions, including aborted ones

Behaviour:
- Reset (synchronous, active-high; takes priority over everything, including mid-transaction):
  - state returns to IDLE
  - bus_out=0, ld_a=ld_b=fp_start=rd_en=0
  - res_valid=0, res_data=0, res_err=0, txn_cnt=0
  - op_ready=1 in the cycle after reset is released
- States: IDLE, SEND_A, SEND_B, START, WAIT, READ, RESP.
- All control outputs are registered-state decodes: asserted only in the state named below, 0 otherwise. bus_out=0 outside SEND_A/SEND_B.
- IDLE:
  - op_ready=1 only in IDLE.
  - On op_valid&&op_ready, op_a/op_b are latched into holding registers; next state is SEND_A.
- SEND_A: bus_out=A_hold, ld_a=1 for exactly one cycle; next state is SEND_B.
- SEND_B: bus_out=B_hold, ld_b=1 for exactly one cycle; next state is START.
- START:
  - fp_start=1 for exactly one cycle; the watchdog counter is cleared.
  - If fp_done=1 in this cycle, next state is READ; else WAIT.
- WAIT:
  - The watchdog increments each cycle.
  - fp_done=1 -> READ.
  - Else, when the watchdog reaches TIMEOUT-1 -> RESP with res_data=32'h7FC00000 (qNaN), res_err=1.
  - If fp_done and the timeout coincide, done wins.
- READ:
  - rd_en=1 for exactly one cycle.
  - bus_in is sampled at the closing edge into res_data; res_err=0.
  - Next state is RESP.
- RESP:
  - res_valid=1, with res_data and res_err held stable until res_valid&&res_ready.
  - On that handshake: txn_cnt increments (wraps at 2^CNT_W), res_valid drops next cycle, next state is IDLE.
- No back-to-back overlap: op_ready=0 from SEND_A through RESP. The next operand is accepted only in IDLE, i.e. at the earliest one cycle after the response handshake.
- Latency (accept edge = cycle 0):
  - SEND_A=1, SEND_B=2, START=3.
  - fp_done first seen in cycle k -> READ=k+1, res_valid from k+2.
  - Minimum (done in START): res_valid in cycle 5.
- fp_done outside START/WAIT is ignored.
- op_a/op_b changes after acceptance have no effect.
- rd_en and ld_a/ld_b are never asserted in the same cycle.

Decomposition:
- Package fp_bus_pkg:
  - state enum fp_host_state_t (IDLE..RESP)
  - localparam FP_QNAN=32'h7FC00000
  - localparam BUS_W=32
- Single module, no sub-module. Watchdog and txn counter stay inline.

Test Plan:
- Basic transaction:
  - Stimulus: reset 2 cycles, then op_a=32'h3F800000, op_b=32'h40000000; the FP model returns fp_done 3 cycles after start, with bus_in=32'h40400000 while rd_en=1.
  - Required response: ld_a in cycle 1 with bus_out=3F800000; ld_b in cycle 2 with bus_out=40000000; fp_start in cycle 3; res_data=40400000, res_err=0, txn_cnt=1.
- Immediate done:
  - Stimulus: fp_done=1 during the START cycle.
  - Required response: READ in cycle 4, res_valid in cycle 5.
- Timeout:
  - Stimulus: TIMEOUT=8, fp_done never asserts.
  - Required response: res_valid with res_data=7FC00000, res_err=1, and rd_en never asserted.
  - Variant: fp_done on the final watchdog cycle -> normal READ path taken.
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles.
  - Required response: res_valid and res_data stable throughout; op_ready=0 while a new op_valid is presented; the op is accepted the cycle after the handshake plus one.
- Reset mid-transaction:
  - Stimulus: assert rst during WAIT.
  - Required response: all outputs 0 and op_ready=1 on the following cycle; txn_cnt=0; a late fp_done is ignored.
- Counter wrap:
  - Stimulus: CNT_W=2, run 5 transactions.
  - Required response: txn_cnt=1.
